// File: rtl/demux132_pkg.sv
// Shared constants, types and helpers for the demux132 serial-to-parallel deserialiser.
package demux132_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEL_W = $clog2(WIDTH);

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [SEL_W:0]   cnt_t;
    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic {FILL, HOLD} state_e;

    function automatic cnt_t popcount(input word_t v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/demux132_if.sv
// Bit-serial input and word-parallel output handshake bundle for demux132_deser.
// DEMUX132_PARITY_EN adds the dout_par signal.
interface demux132_if;
    import demux132_pkg::*;

    logic  din;
    logic  din_valid;
    logic  din_ready;
    sel_t  sel;
    logic  auto_inc;
    logic  clear;
    word_t dout;
    logic  dout_valid;
    logic  dout_ready;
    cnt_t  fill_cnt;
`ifdef DEMUX132_PARITY_EN
    logic  dout_par;
`endif

    modport master (
        output din, din_valid, sel, auto_inc, clear, dout_ready,
        input  din_ready, dout, dout_valid, fill_cnt
`ifdef DEMUX132_PARITY_EN
        , input dout_par
`endif
    );

    modport slave (
        input  din, din_valid, sel, auto_inc, clear, dout_ready,
        output din_ready, dout, dout_valid, fill_cnt
`ifdef DEMUX132_PARITY_EN
        , output dout_par
`endif
    );

endinterface

// File: rtl/demux132_dec.sv
// Enable-gated SEL_W-to-WIDTH one-hot decoder built as a tree of 1-to-2 demux cells.
module demux132_dec
    import demux132_pkg::*;
(
    input  logic  en_i,
    input  sel_t  sel_i,
    output word_t we_o
);

    // Level l consumes select bit SEL_W-1-l, so leaf index equals the select value.
    for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
        logic [(2**(l+1))-1:0] lvl;
        for (genvar k = 0; k < 2**l; k++) begin : g_cell
            logic in_bit;
            if (l == 0) begin : g_root
                assign in_bit = en_i;
            end else begin : g_node
                assign in_bit = g_lvl[l-1].lvl[k];
            end
            assign lvl[2*k]   = in_bit & ~sel_i[SEL_W-1-l];
            assign lvl[2*k+1] = in_bit &  sel_i[SEL_W-1-l];
        end
    end

    assign we_o = g_lvl[SEL_W-1].lvl;

endmodule

// File: rtl/demux132_deser.sv
// Sequential 1-to-32 demux: steers serial bits into a shadow word and presents it when full.
// Define DEMUX132_PARITY_EN to add a registered XOR-of-dout output.
module demux132_deser
    import demux132_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    demux132_if.slave bus
);

    state_e state_q;
    word_t  shadow_q, mask_q, dout_q;
    sel_t   ptr_q;
    cnt_t   fill_q;
    logic   dout_valid_q;
`ifdef DEMUX132_PARITY_EN
    logic   dout_par_q;
`endif

    logic  din_ready;
    logic  accept;
    sel_t  idx;
    word_t we;
    word_t shadow_d, mask_d;

    assign din_ready = rst_n & (state_q == FILL);
    // clear wins over a simultaneous data beat
    assign accept    = bus.din_valid & din_ready & ~bus.clear;
    assign idx       = bus.auto_inc ? ptr_q : bus.sel;

    demux132_dec u_dec (
        .en_i  (accept),
        .sel_i (idx),
        .we_o  (we)
    );

    always_comb begin
        shadow_d = (shadow_q & ~we) | (we & {WIDTH{bus.din}});
        mask_d   = mask_q | we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            shadow_q     <= '0;
            mask_q       <= '0;
            ptr_q        <= '0;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
`ifdef DEMUX132_PARITY_EN
            dout_par_q   <= 1'b0;
`endif
        end else if (bus.clear) begin
            state_q      <= FILL;
            mask_q       <= '0;
            ptr_q        <= '0;
            fill_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        shadow_q <= shadow_d;
                        mask_q   <= mask_d;
                        fill_q   <= popcount(mask_d);
                        if (bus.auto_inc) begin
                            ptr_q <= ptr_q + sel_t'(1);
                        end
                        if (&mask_d) begin
                            state_q      <= HOLD;
                            dout_q       <= shadow_d;
                            dout_valid_q <= 1'b1;
`ifdef DEMUX132_PARITY_EN
                            dout_par_q   <= ^shadow_d;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (bus.dout_ready) begin
                        state_q      <= FILL;
                        mask_q       <= '0;
                        ptr_q        <= '0;
                        fill_q       <= '0;
                        dout_valid_q <= 1'b0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.fill_cnt   = fill_q;
`ifdef DEMUX132_PARITY_EN
    assign bus.dout_par   = dout_par_q;
`endif

endmodule
